// File: rtl/aes_spi_pkg.sv
// rtl/aes_spi_pkg.sv - shared types and constants for the AES/SPI bridge
package aes_spi_pkg;

  localparam int BLOCK_W         = 128;
  localparam int AES_TIMEOUT_DEF = 64;

  typedef enum logic [2:0] {
    WAIT_KEY,
    IDLE,
    START,
    BUSY,
    LOAD
  } state_e;

endpackage

// File: rtl/pulse_sync.sv
// rtl/pulse_sync.sv - two-flop synchronizer followed by a rising-edge detector
module pulse_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse_out
);

  logic s1_q, s1_d;
  logic s2_q, s2_d;
  logic hist_q, hist_d;

  always_comb begin
    s1_d   = async_in;
    s2_d   = s1_q;
    hist_d = s2_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      hist_q <= 1'b0;
    end else begin
      s1_q   <= s1_d;
      s2_q   <= s2_d;
      hist_q <= hist_d;
    end
  end

  assign pulse_out = s2_q & ~hist_q;

endmodule

// File: rtl/aes_spi_bridge.sv
// rtl/aes_spi_bridge.sv - moves SPI frames into an AES core as key/plaintext and
// returns the ciphertext on the next SPI frame.
module aes_spi_bridge
  import aes_spi_pkg::*;
#(
  parameter int AES_TIMEOUT = AES_TIMEOUT_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               spi_done,
  input  logic [BLOCK_W-1:0] spi_rx,
  output logic [BLOCK_W-1:0] spi_tx,
  input  logic               key_reload,
  output logic [BLOCK_W-1:0] aes_key,
  output logic [BLOCK_W-1:0] aes_in,
  output logic               aes_start,
  input  logic               aes_done,
  input  logic [BLOCK_W-1:0] aes_out,
  output logic               key_valid,
  output logic               overrun,
  output logic               timeout
);

  localparam int CNT_W = $clog2(AES_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(AES_TIMEOUT - 1);

  state_e             state_q, state_d;
  logic [BLOCK_W-1:0] spi_tx_q, spi_tx_d;
  logic [BLOCK_W-1:0] aes_key_q, aes_key_d;
  logic [BLOCK_W-1:0] aes_in_q, aes_in_d;
  logic [BLOCK_W-1:0] result_q, result_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               key_valid_q, key_valid_d;
  logic               overrun_q, overrun_d;
  logic               timeout_q, timeout_d;
  logic               reload_pend_q, reload_pend_d;
  logic               frame;

  pulse_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (spi_done),
    .pulse_out(frame)
  );

  always_comb begin
    state_d       = state_q;
    spi_tx_d      = spi_tx_q;
    aes_key_d     = aes_key_q;
    aes_in_d      = aes_in_q;
    result_d      = result_q;
    cnt_d         = cnt_q;
    key_valid_d   = key_valid_q;
    overrun_d     = overrun_q;
    timeout_d     = timeout_q;
    reload_pend_d = reload_pend_q;

    // While an operation is in flight, frames are lost and reload requests wait.
    if (state_q == START || state_q == BUSY || state_q == LOAD) begin
      if (frame)      overrun_d     = 1'b1;
      if (key_reload) reload_pend_d = 1'b1;
    end

    case (state_q)
      WAIT_KEY: begin
        if (frame) begin
          aes_key_d   = spi_rx;
          key_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      IDLE: begin
        if (frame && key_reload) begin
          aes_key_d   = spi_rx;
          key_valid_d = 1'b1;
        end else if (key_reload) begin
          key_valid_d = 1'b0;
          state_d     = WAIT_KEY;
        end else if (frame) begin
          aes_in_d = spi_rx;
          state_d  = START;
        end
      end
      START: begin
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        if (aes_done) begin
          result_d = aes_out;
          state_d  = LOAD;
        end else if (cnt_q >= CNT_LAST) begin
          timeout_d = 1'b1;
          spi_tx_d  = '0;
          state_d   = IDLE;
        end else begin
          cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        end
      end
      LOAD: begin
        spi_tx_d = result_q;
        state_d  = IDLE;
      end
      default: state_d = WAIT_KEY;
    endcase

    // A deferred reload turns the return to IDLE into a wait for a new key.
    if (state_d == IDLE && state_q != IDLE && state_q != WAIT_KEY &&
        (reload_pend_q || key_reload)) begin
      state_d       = WAIT_KEY;
      key_valid_d   = 1'b0;
      reload_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= WAIT_KEY;
      spi_tx_q      <= '0;
      aes_key_q     <= '0;
      aes_in_q      <= '0;
      result_q      <= '0;
      cnt_q         <= '0;
      key_valid_q   <= 1'b0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      reload_pend_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      spi_tx_q      <= spi_tx_d;
      aes_key_q     <= aes_key_d;
      aes_in_q      <= aes_in_d;
      result_q      <= result_d;
      cnt_q         <= cnt_d;
      key_valid_q   <= key_valid_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      reload_pend_q <= reload_pend_d;
    end
  end

  assign spi_tx    = spi_tx_q;
  assign aes_key   = aes_key_q;
  assign aes_in    = aes_in_q;
  assign aes_start = (state_q == START);
  assign key_valid = key_valid_q;
  assign overrun   = overrun_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_aes_spi_bridge.sv
// tb/tb_aes_spi_bridge.sv - scoreboard bench for aes_spi_bridge with an AES stand-in
module tb_aes_spi_bridge;

  localparam int TMO = 8;
  localparam logic [127:0] K0 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P0 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         spi_done = 1'b0;
  logic [127:0] spi_rx = '0;
  logic [127:0] spi_tx;
  logic         key_reload = 1'b0;
  logic [127:0] aes_key;
  logic [127:0] aes_in;
  logic         aes_start;
  logic         aes_done = 1'b0;
  logic [127:0] aes_out = '0;
  logic         key_valid;
  logic         overrun;
  logic         timeout;

  always #5 clk = ~clk;

  aes_spi_bridge #(.AES_TIMEOUT(TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .spi_done  (spi_done),
    .spi_rx    (spi_rx),
    .spi_tx    (spi_tx),
    .key_reload(key_reload),
    .aes_key   (aes_key),
    .aes_in    (aes_in),
    .aes_start (aes_start),
    .aes_done  (aes_done),
    .aes_out   (aes_out),
    .key_valid (key_valid),
    .overrun   (overrun),
    .timeout   (timeout)
  );

  typedef struct {
    bit           is_tx;
    logic [127:0] a;
    logic [127:0] b;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;

  // Reference model of what the bridge should be holding.
  logic [127:0] m_key = '0;
  logic [127:0] m_tx = '0;
  bit           m_kv = 1'b0;
  bit           m_ov = 1'b0;
  bit           m_to = 1'b0;
  bit           m_next_is_key = 1'b1;

  bit stub_en = 1'b1;
  int stub_lat = 2;

  function automatic logic [127:0] cipher(input logic [127:0] k, input logic [127:0] p);
    if (k == K0 && p == P0) return C0;
    return k ^ {p[63:0], p[127:64]} ^ 128'h5a5a_0f0f_3c3c_a5a5_1234_5678_9abc_def0;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  always @(negedge clk) begin : monitor
    static logic [127:0] last_tx = '0;
    exp_t e;
    if (!rst_n) begin
      last_tx = spi_tx;
    end else begin
      if (aes_start) begin
        if (sbq.size() == 0 || sbq[0].is_tx) begin
          total++; bad++;
          $display("FAIL unexpected_start actual key=%h in=%h required none", aes_key, aes_in);
        end else begin
          e = sbq.pop_front();
          check("start_key", aes_key, e.a);
          check("start_in", aes_in, e.b);
        end
      end
      if (spi_tx !== last_tx) begin
        if (sbq.size() == 0 || !sbq[0].is_tx) begin
          total++; bad++;
          $display("FAIL unexpected_tx actual=%h required none", spi_tx);
        end else begin
          e = sbq.pop_front();
          check("spi_tx", spi_tx, e.a);
        end
        last_tx = spi_tx;
      end
    end
  end

  initial begin : aes_stub
    logic [127:0] k, p;
    forever begin
      @(negedge clk);
      if (aes_start && stub_en) begin
        k = aes_key;
        p = aes_in;
        repeat (stub_lat) @(negedge clk);
        aes_out  = cipher(k, p);
        aes_done = 1'b1;
        @(negedge clk);
        aes_done = 1'b0;
      end
    end
  end

  task automatic send_frame(input logic [127:0] d, input int hold, input int post);
    @(negedge clk);
    spi_rx   = d;
    spi_done = 1'b1;
    repeat (hold) @(negedge clk);
    spi_done = 1'b0;
    repeat (post) @(negedge clk);
    if (post > 0) spi_rx = rand128();
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      total++; bad++;
      $display("FAIL %s_drain actual pending=%0d required 0", name, sbq.size());
      sbq.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic push_op(input logic [127:0] d);
    logic [127:0] c;
    sbq.push_back('{is_tx: 1'b0, a: m_key, b: d});
    c = stub_en ? cipher(m_key, d) : '0;
    if (c !== m_tx) sbq.push_back('{is_tx: 1'b1, a: c, b: '0});
    m_tx = c;
    if (!stub_en) m_to = 1'b1;
  endtask

  task automatic data_frame(input logic [127:0] d, input int hold);
    if (m_next_is_key) begin
      m_key = d;
      m_kv = 1'b1;
      m_next_is_key = 1'b0;
      send_frame(d, hold, 4);
      check("key_loaded", aes_key, m_key);
      check("key_valid_set", key_valid, m_kv);
    end else begin
      push_op(d);
      send_frame(d, hold, 4);
      wait_drain("op");
    end
  endtask

  task automatic reload_idle();
    @(negedge clk);
    key_reload = 1'b1;
    @(negedge clk);
    key_reload = 1'b0;
    m_kv = 1'b0;
    m_next_is_key = 1'b1;
    repeat (2) @(negedge clk);
    check("reload_idle_kv", key_valid, m_kv);
  endtask

  task automatic reload_busy(input logic [127:0] d);
    stub_lat = 5;
    push_op(d);
    send_frame(d, 4, 0);
    @(negedge clk);
    key_reload = 1'b1;
    @(negedge clk);
    key_reload = 1'b0;
    m_kv = 1'b0;
    m_next_is_key = 1'b1;
    wait_drain("reload_busy");
    check("reload_busy_kv", key_valid, m_kv);
  endtask

  task automatic check_all(input string tag);
    check({tag, "_spi_tx"}, spi_tx, m_tx);
    check({tag, "_key"}, aes_key, m_key);
    check({tag, "_kv"}, key_valid, m_kv);
    check({tag, "_ovr"}, overrun, m_ov);
    check({tag, "_tmo"}, timeout, m_to);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=stuck required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [127:0] d1;
    int n;
    repeat (3) @(negedge clk);
    check("rst_aes_in", aes_in, '0);
    check("rst_start", aes_start, 1'b0);
    check_all("rst");
    #2 rst_n = 1'b1;

    // Key then known-answer plaintext, each frame held high for 10 cycles.
    data_frame(K0, 10);
    data_frame(P0, 10);
    check("kat_tx", spi_tx, C0);
    check("kat_ovr", overrun, 1'b0);

    // Second frame lands while the core is busy.
    stub_lat = 6;
    d1 = rand128();
    push_op(d1);
    send_frame(d1, 4, 0);
    send_frame(rand128(), 4, 4);
    m_ov = 1'b1;
    wait_drain("overrun");
    check("ovr_aes_in", aes_in, d1);
    check_all("ovr");

    // Core never answers.
    stub_en = 1'b0;
    d1 = rand128();
    push_op(d1);
    fork
      send_frame(d1, 4, 4);
      begin
        n = 0;
        @(negedge clk);
        while (!aes_start && n < 50) begin @(negedge clk); n++; end
        n = 0;
        while (n < 30) begin
          @(negedge clk);
          n++;
          if (timeout) break;
        end
        check("tmo_cycles", n, TMO + 1);
      end
    join
    wait_drain("timeout");
    check_all("tmo");
    stub_en = 1'b1;
    stub_lat = 3;
    data_frame(rand128(), 5);

    reload_busy(rand128());
    data_frame(rand128(), 6);
    check_all("rb");
    reload_idle();
    data_frame(rand128(), 4);
    data_frame(rand128(), 4);

    // Reset while the core is working; its late answer must be ignored.
    stub_lat = 6;
    d1 = rand128();
    sbq.push_back('{is_tx: 1'b0, a: m_key, b: d1});
    send_frame(d1, 4, 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (8) @(negedge clk);
    sbq.delete();
    m_key = '0; m_tx = '0; m_kv = 1'b0; m_ov = 1'b0; m_to = 1'b0; m_next_is_key = 1'b1;
    check("rb_aes_in", aes_in, '0);
    check_all("midrst");

    for (int i = 0; i < 30; i++) begin
      stub_lat = $urandom_range(1, 6);
      case ($urandom_range(0, 9))
        0:       reload_idle();
        1:       if (!m_next_is_key) reload_busy(rand128());
        default: data_frame(rand128(), $urandom_range(4, 10));
      endcase
    end
    check_all("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
